leon_mem_stub: RTL
==================

Name: leon_mem_stub

Overview:
- Synthesizable cache-response emulator that replaces the LEON icache/dcache outputs in integer-unit tests.
- Instruction side: feeds queued instructions on each fetch and substitutes NOP when starved.
- Data side: FSM answers loads from a queue with programmable wait states, and captures stores into a FIFO for the bench to drain.
- Generalises hand-driven single-word instruction/data pokes to parametrised widths, depths and latency.

Parameters:
DATA_W, 32, width of instruction, load, store and address words
IQ_DEPTH, 8, instruction queue depth (power of 2, >=2)
LQ_DEPTH, 4, load-data queue depth (power of 2, >=2)
SQ_DEPTH, 4, store-capture FIFO depth (power of 2, >=2)
WAIT_W, 4, width of the runtime wait-state count
NOP_INST, 32'h01000000, word issued when the instruction queue is empty
LD_DEFAULT, 32'h00000100, load data returned when the load queue is empty

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
inst_valid  in  1  bench pushes inst_data into the instruction queue
inst_data  in  DATA_W  instruction word
inst_ready  out  1  instruction queue not full
ld_valid  in  1  bench pushes ld_data into the load queue
ld_data  in  DATA_W  load response word
ld_ready  out  1  load queue not full
st_valid  out  1  store FIFO head valid
st_addr  out  DATA_W  captured store address
st_data  out  DATA_W  captured store data
st_ready  in  1  bench pops the store FIFO head
ic_req  in  1  core fetch strobe
ic_data  out  DATA_W  instruction to core
dc_req  in  1  core data access strobe
dc_write  in  1  1 = store, 0 = load (qualified by dc_req)
dc_addr  in  DATA_W  access address
dc_wdata  in  DATA_W  store data
dc_wait  in  WAIT_W  wait states for this access, sampled at acceptance
dc_rdata  out  DATA_W  load data to core
dc_hold_n  out  1  active-low hold to core
dc_mds_n  out  1  active-low one-cycle load-data strobe
nop_cnt  out  16  count of NOPs issued, saturating at 16'hFFFF

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - ic_data=NOP_INST, dc_rdata=0, dc_hold_n=1, dc_mds_n=1, nop_cnt=0, state=IDLE.
  - All queues empty: st_valid=0, inst_ready=1, ld_ready=1.
  - Reset mid-access discards all in-flight state; no partial pops.
- Queue handshakes:
  - A push is accepted when valid && ready. ready depends on fullness only, so a push to a full queue is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty queue: both take effect, count unchanged.
  - No bypass: a word pushed into an empty queue is poppable from the next cycle.
  - Pointers wrap modulo depth.
- Instruction path, 1-cycle registered latency:
  - ic_req=1 with queue non-empty: ic_data<=head, pop.
  - ic_req=1 with queue empty: ic_data<=NOP_INST, nop_cnt++ (saturating).
  - ic_req=0: ic_data holds its value.
- Data FSM states: IDLE, WAIT, RESP, SBLK.
  - IDLE: dc_req=1 latches dc_write/addr/wdata and loads wcnt<=dc_wait. If dc_wait=0, go to RESP; otherwise go to WAIT with dc_hold_n<=0.
  - WAIT: dc_hold_n=0; wcnt decrements each cycle. When wcnt reaches 1, go to RESP.
  - RESP, load: dc_rdata<=load-queue head (pop), or LD_DEFAULT if empty; dc_mds_n=0 for exactly this cycle; dc_hold_n=1; return to IDLE.
  - RESP, store: if the store FIFO is not full, push {addr,wdata}, dc_hold_n=1, return to IDLE. If full, go to SBLK with dc_hold_n=0.
  - SBLK: dc_hold_n=0 until the FIFO has space, which includes a same-cycle st_ready pop. Then push and go to IDLE with dc_hold_n=1.
- dc_req outside IDLE is ignored.
- Load timing: request accepted at edge k with dc_wait=N≥1 gives dc_hold_n low for cycles k+1..k+N, with dc_rdata valid and dc_mds_n low in cycle k+N+1. With N=0, data arrives in cycle k+1 and dc_hold_n never drops.
- Stores never assert dc_mds_n.

Test Plan:
- Reset then push 3 instructions (32'h8E00C002, 32'h82006001, 32'h01000000) and pulse ic_req 5 cycles → ic_data shows the three words in order, then NOP twice; nop_cnt=2.
- Push 9 instructions into IQ_DEPTH=8 → inst_ready=0 after 8; the 9th push is refused; pops return the first 8 unchanged.
- Load with dc_wait=3 and 32'hDEADBEEF queued → dc_hold_n low 3 cycles, then dc_rdata=32'hDEADBEEF with a single-cycle dc_mds_n=0. Repeat with the queue empty → dc_rdata=32'h100.
- 5 stores (addr 32'h40+i, data i) with st_ready=0 → 4 captured; 5th holds dc_hold_n=0 in SBLK. Pulse st_ready once → pops addr 32'h40, 5th is captured, dc_hold_n=1.
- Assert rst mid-WAIT with 2 instructions queued → all outputs return to reset values immediately; queues empty; a following ic_req yields NOP.

Source files
------------

// File: rtl/leon_mem_stub.sv
// leon_mem_stub: cache-response emulator standing in for the LEON icache and
// dcache during integer-unit tests.
//   Bench side : inst_valid/inst_data/inst_ready  push instruction words
//                ld_valid/ld_data/ld_ready        push load response words
//                st_valid/st_addr/st_data/st_ready drain captured stores
//   Core side  : ic_req/ic_data                   fetch, 1-cycle latency, NOP when starved
//                dc_req/dc_write/dc_addr/dc_wdata/dc_wait  data access request
//                dc_rdata/dc_hold_n/dc_mds_n      data response and handshake
//   Status     : nop_cnt                          saturating count of NOPs issued
//   Reset      : rst, asynchronous, active low.

// Simple circular FIFO shared by the three queues. The caller qualifies push
// and pop; a push while full is legal only together with a pop.
module leon_mem_stub_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_r [DEPTH];
   logic [AW-1:0] wp_r;
   logic [AW-1:0] rp_r;
   logic [AW:0]   cnt_r;

   assign head  = mem_r[rp_r];
   assign empty = (cnt_r == {(AW+1){1'b0}});
   assign full  = (cnt_r == (AW+1)'(DEPTH));

   // Storage array; contents need no reset because cnt_r gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wp_r] <= wdata;
      end
   end

   // Pointers and occupancy; power-of-two depth makes pointer wrap free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_r  <= {AW{1'b0}};
         rp_r  <= {AW{1'b0}};
         cnt_r <= {(AW+1){1'b0}};
      end else begin
         if (push) begin
            wp_r <= wp_r + AW'(1);
         end
         if (pop) begin
            rp_r <= rp_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end
endmodule

module leon_mem_stub #(
   parameter int                DATA_W     = 32,
   parameter int                IQ_DEPTH   = 8,
   parameter int                LQ_DEPTH   = 4,
   parameter int                SQ_DEPTH   = 4,
   parameter int                WAIT_W     = 4,
   parameter logic [DATA_W-1:0] NOP_INST   = 32'h01000000,
   parameter logic [DATA_W-1:0] LD_DEFAULT = 32'h00000100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_valid,
   input  logic [DATA_W-1:0] inst_data,
   output logic              inst_ready,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              st_valid,
   output logic [DATA_W-1:0] st_addr,
   output logic [DATA_W-1:0] st_data,
   input  logic              st_ready,
   input  logic              ic_req,
   output logic [DATA_W-1:0] ic_data,
   input  logic              dc_req,
   input  logic              dc_write,
   input  logic [DATA_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   input  logic [WAIT_W-1:0] dc_wait,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_hold_n,
   output logic              dc_mds_n,
   output logic [15:0]       nop_cnt
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_SBLK} state_t;

   state_t            state_r;
   logic              wr_r;
   logic [DATA_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [WAIT_W-1:0] wcnt_r;
   logic [DATA_W-1:0] ic_data_r;
   logic [15:0]       nop_cnt_r;
   logic [DATA_W-1:0] rdata_r;
   logic              hold_n_r;
   logic              mds_n_r;

   logic [DATA_W-1:0]   iq_head_s;
   logic                iq_empty_s, iq_full_s, iq_pop_s;
   logic [DATA_W-1:0]   lq_head_s;
   logic                lq_empty_s, lq_full_s, lq_pop_s;
   logic [2*DATA_W-1:0] sq_head_s;
   logic                sq_empty_s, sq_full_s, sq_push_s, sq_pop_s, sq_space_s;
   logic                enter_resp_s;
   logic                acc_write_s;
   logic [DATA_W-1:0]   acc_addr_s;
   logic [DATA_W-1:0]   acc_wdata_s;

   assign iq_pop_s = ic_req && !iq_empty_s;
   assign sq_pop_s = st_ready && !sq_empty_s;

   leon_mem_stub_fifo #(.W(DATA_W), .DEPTH(IQ_DEPTH)) u_iq (
      .clk(clk), .rst(rst), .push(inst_valid && !iq_full_s), .wdata(inst_data),
      .pop(iq_pop_s), .head(iq_head_s), .empty(iq_empty_s), .full(iq_full_s));

   leon_mem_stub_fifo #(.W(DATA_W), .DEPTH(LQ_DEPTH)) u_lq (
      .clk(clk), .rst(rst), .push(ld_valid && !lq_full_s), .wdata(ld_data),
      .pop(lq_pop_s), .head(lq_head_s), .empty(lq_empty_s), .full(lq_full_s));

   leon_mem_stub_fifo #(.W(2*DATA_W), .DEPTH(SQ_DEPTH)) u_sq (
      .clk(clk), .rst(rst), .push(sq_push_s), .wdata({acc_addr_s, acc_wdata_s}),
      .pop(sq_pop_s), .head(sq_head_s), .empty(sq_empty_s), .full(sq_full_s));

   assign inst_ready = !iq_full_s;
   assign ld_ready   = !lq_full_s;
   assign st_valid   = !sq_empty_s;
   assign st_addr    = sq_head_s[2*DATA_W-1:DATA_W];
   assign st_data    = sq_head_s[DATA_W-1:0];
   assign ic_data    = ic_data_r;
   assign nop_cnt    = nop_cnt_r;
   assign dc_rdata   = rdata_r;
   assign dc_hold_n  = hold_n_r;
   assign dc_mds_n   = mds_n_r;

   // Response is produced on the edge that enters RESP so that the registered
   // outputs are valid during the RESP cycle; in IDLE the live request is used.
   always_comb begin
      acc_write_s  = wr_r;
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
      enter_resp_s = 1'b0;
      if (state_r == ST_IDLE) begin
         acc_write_s = dc_write;
         acc_addr_s  = dc_addr;
         acc_wdata_s = dc_wdata;
      end else begin
         acc_write_s = wr_r;
      end
      case (state_r)
         ST_IDLE: enter_resp_s = dc_req && (dc_wait == {WAIT_W{1'b0}});
         ST_WAIT: enter_resp_s = (wcnt_r == WAIT_W'(1));
         default: enter_resp_s = 1'b0;
      endcase
      // A blocked store may use the slot freed by a same-cycle drain.
      sq_space_s = !sq_full_s || st_ready;
      lq_pop_s   = enter_resp_s && !acc_write_s && !lq_empty_s;
      sq_push_s  = (enter_resp_s && acc_write_s && !sq_full_s) ||
                   ((state_r == ST_SBLK) && sq_space_s);
   end

   // Instruction fetch: registered head word, or NOP with a saturating count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ic_data_r <= NOP_INST;
         nop_cnt_r <= 16'h0000;
      end else if (ic_req) begin
         if (!iq_empty_s) begin
            ic_data_r <= iq_head_s;
         end else begin
            ic_data_r <= NOP_INST;
            if (nop_cnt_r != 16'hFFFF) begin
               nop_cnt_r <= nop_cnt_r + 16'h0001;
            end
         end
      end
   end

   // Data-side FSM; the enter_resp_s block at the end overrides the case arm.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         wr_r     <= 1'b0;
         addr_r   <= {DATA_W{1'b0}};
         wdata_r  <= {DATA_W{1'b0}};
         wcnt_r   <= {WAIT_W{1'b0}};
         rdata_r  <= {DATA_W{1'b0}};
         hold_n_r <= 1'b1;
         mds_n_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (dc_req) begin
                  wr_r    <= dc_write;
                  addr_r  <= dc_addr;
                  wdata_r <= dc_wdata;
                  wcnt_r  <= dc_wait;
                  if (!enter_resp_s) begin
                     state_r  <= ST_WAIT;
                     hold_n_r <= 1'b0;
                  end
               end
            end
            ST_WAIT: wcnt_r <= wcnt_r - WAIT_W'(1);
            ST_RESP: begin
               mds_n_r <= 1'b1;
               state_r <= ST_IDLE;
            end
            ST_SBLK: begin
               if (sq_space_s) begin
                  hold_n_r <= 1'b1;
                  state_r  <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
         if (enter_resp_s) begin
            if (!acc_write_s) begin
               rdata_r  <= lq_empty_s ? LD_DEFAULT : lq_head_s;
               mds_n_r  <= 1'b0;
               hold_n_r <= 1'b1;
               state_r  <= ST_RESP;
            end else if (!sq_full_s) begin
               hold_n_r <= 1'b1;
               state_r  <= ST_RESP;
            end else begin
               hold_n_r <= 1'b0;
               state_r  <= ST_SBLK;
            end
         end
      end
   end
endmodule
